// File: rtl/extend_pipe_if.sv
// Handshake bus for extend_pipe: immediate/mode producer side and extended-word consumer side.
// The master modport is the environment; the slave modport is the extend_pipe block.
interface extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
) ();
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             IN_VALID;
    logic             IN_READY;
    logic [IN_W-1:0]  A;
    logic [1:0]       MODE;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [OUT_W-1:0] O;
    logic             ERR;
    logic [CNT_W-1:0] COUNT;

    modport master (
        output IN_VALID, A, MODE, OUT_READY,
        input  IN_READY, OUT_VALID, O, ERR, COUNT
    );

    modport slave (
        input  IN_VALID, A, MODE, OUT_READY,
        output IN_READY, OUT_VALID, O, ERR, COUNT
    );
endinterface

// File: rtl/extend_pipe.sv
// Immediate extension unit feeding a DEPTH-entry circular FIFO of {ERR, O} results.
// Define EXTEND_PIPE_SHL2_EN to enable the branch-offset mode (MODE 10); otherwise it is flagged with ERR.
module extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           FLUSH,
    extend_pipe_if.slave   bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EXT_W = OUT_W - IN_W;

    generate
        if ((IN_W >= OUT_W) || (OUT_W < IN_W + 2) || (DEPTH < 1)) begin : g_param_check
            $error("extend_pipe: illegal parameters IN_W=%0d OUT_W=%0d DEPTH=%0d", IN_W, OUT_W, DEPTH);
        end
    endgenerate

    // Returns {err, extended word} for one immediate/mode pair.
    function automatic logic [OUT_W:0] extend(input logic [IN_W-1:0] a, input logic [1:0] mode);
        logic [OUT_W-1:0] sext;
        logic [OUT_W-1:0] res;
        logic             err;
        sext = {{EXT_W{a[IN_W-1]}}, a};
        res  = sext;
        err  = 1'b0;
        case (mode)
            2'b00: res = {{EXT_W{1'b0}}, a};
            2'b01: res = sext;
`ifdef EXTEND_PIPE_SHL2_EN
            2'b10: res = {sext[OUT_W-3:0], 2'b00};
`else
            2'b10: begin
                res = sext;
                err = 1'b1;
            end
`endif
            2'b11: res = {a, {EXT_W{1'b0}}};
            default: begin
                res = sext;
                err = 1'b0;
            end
        endcase
        return {err, res};
    endfunction

    // Pointer advance with explicit wrap from DEPTH-1 back to 0.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(DEPTH - 1)) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    logic [OUT_W:0]   mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             rdy_en_r;

    logic             in_ready_s;
    logic             out_valid_s;
    logic             push_s;
    logic             pop_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic [OUT_W:0]   ext_s;
    logic [OUT_W:0]   head_s;

    // Handshake qualification; FLUSH blocks both directions in the same cycle.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        if (rdy_en_r && (count_r < CNT_W'(DEPTH)) && !FLUSH) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        out_valid_s = (count_r != {CNT_W{1'b0}});
        push_s      = bus.IN_VALID && in_ready_s;
        pop_s       = out_valid_s && bus.OUT_READY && !FLUSH;
    end

    // Occupancy update: simultaneous push and pop cancel out.
    always_comb begin
        count_nxt_s = count_r;
        if (FLUSH) begin
            count_nxt_s = {CNT_W{1'b0}};
        end else if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Extension is evaluated only when the word is actually accepted.
    always_comb begin
        ext_s = {(OUT_W + 1){1'b0}};
        if (push_s) begin
            ext_s = extend(bus.A, bus.MODE);
        end else begin
            ext_s = {(OUT_W + 1){1'b0}};
        end
    end

    // Control state: pointers, occupancy and the post-reset ready enable.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            rdy_en_r <= 1'b0;
        end else begin
            rdy_en_r <= 1'b1;
            count_r  <= count_nxt_s;
            if (FLUSH) begin
                rd_ptr_r <= {PTR_W{1'b0}};
                wr_ptr_r <= {PTR_W{1'b0}};
            end else begin
                if (push_s) begin
                    wr_ptr_r <= ptr_inc(wr_ptr_r);
                end
                if (pop_s) begin
                    rd_ptr_r <= ptr_inc(rd_ptr_r);
                end
            end
        end
    end

    // Result storage; reset clears every entry so the head reads as zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {(OUT_W + 1){1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= ext_s;
        end
    end

    // Head entry is a direct read of registered storage, so it holds while not popped.
    always_comb begin
        head_s = mem_r[rd_ptr_r];
    end

    assign bus.IN_READY  = in_ready_s;
    assign bus.OUT_VALID = out_valid_s;
    assign bus.O         = head_s[OUT_W-1:0];
    assign bus.ERR       = head_s[OUT_W];
    assign bus.COUNT     = count_r;
endmodule

// File: tb/tb_extend_pipe.sv
// Self-checking bench for extend_pipe (IN_W=16, OUT_W=32, DEPTH=2): directed cases plus random traffic
// compared against a queue-based reference model.
module tb_extend_pipe;
    logic clk;
    logic rst_n;
    logic flush;
    int   tests;
    int   fails;
    logic        model_rdy;
    logic [32:0] q [$];

    extend_pipe_if #(.IN_W(16), .OUT_W(32), .DEPTH(2)) bus ();

    extend_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(2)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .FLUSH (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] ref_ext(input logic [15:0] a, input logic [1:0] m);
        longint sa;
        longint ua;
        longint r;
        logic   e;
        sa = longint'($signed(a));
        ua = longint'(a);
        e  = 1'b0;
        case (m)
            2'd0: r = ua;
            2'd1: r = sa;
`ifdef EXTEND_PIPE_SHL2_EN
            2'd2: r = sa * 4;
`else
            2'd2: begin
                r = sa;
                e = 1'b1;
            end
`endif
            default: r = ua * 65536;
        endcase
        return {e, r[31:0]};
    endfunction

    // One clock: drive inputs, check outputs against the model, step the model at the edge.
    task automatic cycle(input logic iv, input logic [15:0] a, input logic [1:0] m,
                         input logic ordy, input logic fl);
        logic exp_rdy;
        logic exp_vld;
        logic do_push;
        logic do_pop;
        bus.IN_VALID  = iv;
        bus.A         = a;
        bus.MODE      = m;
        bus.OUT_READY = ordy;
        flush         = fl;
        #1;
        exp_rdy = model_rdy && (q.size() < 2) && !fl;
        exp_vld = (q.size() != 0);
        chk("in_ready", 64'(bus.IN_READY), 64'(exp_rdy));
        chk("out_valid", 64'(bus.OUT_VALID), 64'(exp_vld));
        chk("count", 64'(bus.COUNT), 64'(q.size()));
        if (exp_vld) begin
            chk("head_o", 64'(bus.O), 64'(q[0][31:0]));
            chk("head_err", 64'(bus.ERR), 64'(q[0][32]));
        end
        do_push = iv && exp_rdy;
        do_pop  = exp_vld && ordy && !fl;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            model_rdy = 1'b0;
        end else begin
            model_rdy = 1'b1;
            if (fl) begin
                q.delete();
            end else begin
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back(ref_ext(a, m));
            end
        end
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_rdy = 1'b0;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.IN_VALID  = 1'b0;
        bus.A         = 16'h0000;
        bus.MODE      = 2'b00;
        bus.OUT_READY = 1'b0;
        #12;
        chk("rst_count", 64'(bus.COUNT), 64'd0);
        chk("rst_out_valid", 64'(bus.OUT_VALID), 64'd0);
        chk("rst_in_ready", 64'(bus.IN_READY), 64'd0);
        chk("rst_o", 64'(bus.O), 64'd0);
        chk("rst_err", 64'(bus.ERR), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 16'h0, 2'd0, 1'b0, 1'b0);
        chk("ready_after_reset", 64'(bus.IN_READY), 64'd1);

        // Sign then zero extension, each visible one cycle after acceptance.
        cycle(1'b1, 16'h8001, 2'd1, 1'b0, 1'b0);
        chk("sext_8001", 64'(bus.O), 64'h0000_0000_FFFF_8001);
        cycle(1'b1, 16'h8001, 2'd0, 1'b1, 1'b0);
        chk("zext_8001", 64'(bus.O), 64'h0000_0000_0000_8001);
        cycle(1'b0, 16'h0, 2'd0, 1'b1, 1'b0);
        chk("drained", 64'(bus.COUNT), 64'd0);

        // Branch offset and upper immediate.
        cycle(1'b1, 16'hFFFF, 2'd2, 1'b1, 1'b0);
`ifdef EXTEND_PIPE_SHL2_EN
        chk("branch_o", 64'(bus.O), 64'h0000_0000_FFFF_FFFC);
        chk("branch_err", 64'(bus.ERR), 64'd0);
`else
        chk("branch_o", 64'(bus.O), 64'h0000_0000_FFFF_FFFF);
        chk("branch_err", 64'(bus.ERR), 64'd1);
`endif
        cycle(1'b1, 16'h1234, 2'd3, 1'b1, 1'b0);
        chk("upper_o", 64'(bus.O), 64'h0000_0000_1234_0000);
        chk("upper_err", 64'(bus.ERR), 64'd0);
        cycle(1'b0, 16'h0, 2'd0, 1'b1, 1'b0);

        // Full FIFO backpressure: third word must be dropped.
        cycle(1'b1, 16'h0011, 2'd0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0022, 2'd0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0033, 2'd0, 1'b0, 1'b0);
        chk("full_count", 64'(bus.COUNT), 64'd2);
        chk("full_in_ready", 64'(bus.IN_READY), 64'd0);
        chk("full_head", 64'(bus.O), 64'h0000_0000_0000_0011);
        cycle(1'b0, 16'h0, 2'd0, 1'b1, 1'b0);
        chk("second_word", 64'(bus.O), 64'h0000_0000_0000_0022);
        cycle(1'b0, 16'h0, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 16'(16'h0100 + i), 2'(i), 1'b1, 1'b0);
        end
        cycle(1'b0, 16'h0, 2'd0, 1'b1, 1'b0);

        // Steady state push+pop at COUNT=1, then flush drops the input.
        cycle(1'b1, 16'hA000, 2'd1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 16'(16'hA001 + i), 2'd0, 1'b1, 1'b0);
            chk("pushpop_count", 64'(bus.COUNT), 64'd1);
        end
        cycle(1'b1, 16'hBEEF, 2'd0, 1'b1, 1'b1);
        chk("flush_count", 64'(bus.COUNT), 64'd0);
        chk("flush_out_valid", 64'(bus.OUT_VALID), 64'd0);

        // Asynchronous reset mid-cycle with a full FIFO.
        cycle(1'b1, 16'h5555, 2'd0, 1'b0, 1'b0);
        cycle(1'b1, 16'h6666, 2'd1, 1'b0, 1'b0);
        chk("pre_rst_count", 64'(bus.COUNT), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 64'(bus.OUT_VALID), 64'd0);
        chk("async_o", 64'(bus.O), 64'd0);
        chk("async_count", 64'(bus.COUNT), 64'd0);
        q.delete();
        model_rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 16'h7777, 2'd0, 1'b0, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom),
                  1'(($urandom % 4) != 0), 1'(($urandom % 16) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/extend_pipe.md
EXTEND_PIPE -- requirements
Module: extend_pipe

Interface
Parameters, one per line: name, default, meaning.
- REQ-001: The block SHALL have parameter IN_W, default 16, giving the input immediate width.
- REQ-002: The block SHALL have parameter OUT_W, default 32, giving the output word width.
- REQ-003: The block SHALL have parameter DEPTH, default 2, giving the output buffer entries.

Ports, one per line: name, direction, width, meaning.
- REQ-004: CLK, input, 1 -- the single clock; all state SHALL update on the rising edge.
- REQ-005: RST_N, input, 1 -- the reset, which SHALL be asynchronous and active-low.
- REQ-006: FLUSH, input, 1 -- a synchronous clear of all buffered entries.
- REQ-007: IN_VALID, input, 1 -- the producer has a word.
- REQ-008: IN_READY, output, 1 -- the block can accept a word.
- REQ-009: A, input, IN_W -- the immediate operand.
- REQ-010: MODE, input, 2 -- the extension mode, captured together with A.
- REQ-011: OUT_VALID, output, 1 -- the head entry is valid.
- REQ-012: OUT_READY, input, 1 -- the consumer takes the head entry.
- REQ-013: O, output, OUT_W -- the extended result.
- REQ-014: ERR, output, 1 -- the head entry was produced from an unsupported mode.
- REQ-015: COUNT, output, clog2(DEPTH+1) -- the number of occupied entries.

Function
- REQ-016: A transfer SHALL occur in any cycle where IN_VALID=1, IN_READY=1 and FLUSH=0; a pop SHALL occur in any cycle where OUT_VALID=1, OUT_READY=1 and FLUSH=0.
- REQ-017: MODE 00 (zero extend): O SHALL have its upper OUT_W-IN_W bits equal to 0 and its low bits equal to A.
- REQ-018: MODE 01 (sign extend): O SHALL have its upper OUT_W-IN_W bits equal to A[IN_W-1] and its low bits equal to A.
- REQ-019: MODE 10 (branch offset): O SHALL be the sign-extended A shifted left by 2, truncated to OUT_W bits.
- REQ-020: MODE 11 (upper immediate): O SHALL be A shifted left by OUT_W-IN_W, with the lower bits zero-filled.
- REQ-021: The extension SHALL be computed at acceptance; the result, and ERR, SHALL be stored in a DEPTH-entry circular FIFO.
- REQ-022: Latency SHALL be 1 cycle: a word accepted at edge N SHALL appear on O with OUT_VALID=1 after edge N if the FIFO was empty.
- REQ-023: IN_READY SHALL equal (COUNT<DEPTH) AND NOT FLUSH; it SHALL depend combinationally on these alone, not on OUT_READY.
- REQ-024: OUT_VALID SHALL equal (COUNT!=0).
- REQ-025: O and ERR SHALL present the head entry; their values SHALL be stable while OUT_VALID=1 and OUT_READY=0.
- REQ-026: Push and pop in the same cycle SHALL leave COUNT unchanged and advance both pointers.
- REQ-027: When the FIFO is full, IN_VALID SHALL be ignored and A and MODE SHALL not be sampled.
- REQ-028: When the FIFO is empty, OUT_READY SHALL be ignored.
- REQ-029: The read and write pointers SHALL wrap from DEPTH-1 to 0.
- REQ-030: FLUSH=1 SHALL set COUNT and both pointers to 0 at the next edge; a simultaneous push and pop SHALL be discarded.
- REQ-031: Elaboration SHALL fail if IN_W>=OUT_W, if OUT_W<IN_W+2, or if DEPTH<1.

Reset
- REQ-032: RST_N=0 SHALL immediately force COUNT=0, both pointers=0, OUT_VALID=0, IN_READY=0, O=0, ERR=0, and clear all storage to 0.
- REQ-033: Assertion of RST_N mid-transfer SHALL discard all buffered words.
- REQ-034: IN_READY SHALL rise in the first cycle after RST_N deasserts.

Configuration
- REQ-035: Macro EXTEND_PIPE_SHL2_EN, when defined, SHALL compile in MODE 10 as specified in REQ-019, with ERR=0 for all modes.
- REQ-036: Without EXTEND_PIPE_SHL2_EN, MODE 10 SHALL produce the MODE 01 result with ERR=1 for that entry; all other modes SHALL produce ERR=0.

Verification (IN_W=16, OUT_W=32, DEPTH=2)
- REQ-037: Push A=16'h8001 in MODE 01, then in MODE 00 -> O=32'hFFFF8001, then 32'h00008001, each one cycle after its acceptance.
- REQ-038: Push A=16'hFFFF in MODE 10 -> with macro, O=32'hFFFFFFFC and ERR=0; without macro, O=32'hFFFFFFFF and ERR=1.
- REQ-039: Push A=16'h1234 in MODE 11 -> O=32'h12340000.
- REQ-040: Hold OUT_READY=0 and push 3 words -> COUNT=2, IN_READY=0, third word never accepted; release OUT_READY -> first two words emerge in order, with wrap verified over 5 further words.
- REQ-041: With COUNT=1, apply simultaneous push and pop for 4 cycles -> COUNT stays 1 and data order is preserved; FLUSH with IN_VALID=1 -> COUNT=0, input dropped.
- REQ-042: Drop RST_N asynchronously mid-cycle with COUNT=2 -> OUT_VALID=0 and O=0 before the next edge.
